// File: rtl/reset_sequencer.sv
// reset_sequencer: arbitrates reset requests into a held, cooled-down system reset with cause tracking
module reset_sequencer #(
   parameter int unsigned HOLD_CYCLES     = 200,
   parameter int unsigned COOLDOWN_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] req,
   input  logic       cause_clr,
   output logic       sys_rst_n,
   output logic [3:0] cause,
   output logic [7:0] rst_count,
   output logic       busy
);
   typedef enum logic [1:0] {ASSERT, COOLDOWN, IDLE} state_t;
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] COOL_LAST = 16'(COOLDOWN_CYCLES - 1);
   state_t      state_q;
   logic [15:0] ctr_q;
   logic        sys_rst_n_q;
   logic [3:0]  cause_q;
   logic [7:0]  count_q;
   logic        busy_q;
   logic [2:0]  pending_q;
   logic [2:0]  eff_d;
   assign eff_d     = req | pending_q;
   assign sys_rst_n = sys_rst_n_q;
   assign cause     = cause_q;
   assign rst_count = count_q;
   assign busy      = busy_q;
   // sequencer: hold reset, then cool down, then accept live or deferred requests
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ASSERT;
         ctr_q       <= '0;
         sys_rst_n_q <= 1'b0;
         cause_q     <= 4'b1000;
         count_q     <= '0;
         busy_q      <= 1'b1;
         pending_q   <= '0;
      end else begin
         case (state_q)
            ASSERT: begin
               if (req != 3'b000) begin
                  ctr_q        <= '0;
                  cause_q[2:0] <= cause_q[2:0] | req;
               end else if (ctr_q == HOLD_LAST) begin
                  sys_rst_n_q <= 1'b1;
                  ctr_q       <= '0;
                  if (COOLDOWN_CYCLES == 0) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= COOLDOWN;
                  end
               end else begin
                  ctr_q <= ctr_q + 16'd1;
               end
            end
            COOLDOWN: begin
               pending_q <= pending_q | req;
               if (cause_clr) cause_q <= '0;
               if (ctr_q == COOL_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  ctr_q   <= '0;
               end else begin
                  ctr_q <= ctr_q + 16'd1;
               end
            end
            default: begin
               if (eff_d != 3'b000) begin
                  cause_q     <= {1'b0, eff_d};
                  pending_q   <= '0;
                  ctr_q       <= '0;
                  count_q     <= (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                  sys_rst_n_q <= 1'b0;
                  state_q     <= ASSERT;
                  busy_q      <= 1'b1;
               end else if (cause_clr) begin
                  cause_q <= '0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios plus randomized traffic against a countdown reference model
module tb_reset_sequencer;
   localparam int HOLD = 200;
   localparam int COOL = 16;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] req = 3'b000;
   logic       cause_clr = 1'b0;
   logic       sys_rst_n;
   logic [3:0] cause;
   logic [7:0] rst_count;
   logic       busy;
   int n_tests = 0;
   int n_fail = 0;

   reset_sequencer #(.HOLD_CYCLES(HOLD), .COOLDOWN_CYCLES(COOL)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .cause_clr(cause_clr),
      .sys_rst_n(sys_rst_n), .cause(cause), .rst_count(rst_count), .busy(busy)
   );

   always #5 clk = ~clk;

   // reference model: remaining hold and cooldown cycles as plain countdowns
   int         hold_left, cool_left, m_count;
   logic [3:0] m_cause;
   logic [2:0] m_pend;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_left = HOLD; cool_left = 0; m_count = 0; m_cause = 4'b1000; m_pend = 3'b000;
      end else if (hold_left > 0) begin
         if (req != 3'b000) begin
            hold_left = HOLD;
            m_cause[2:0] = m_cause[2:0] | req;
         end else begin
            hold_left--;
            if (hold_left == 0) cool_left = COOL;
         end
      end else if (cool_left > 0) begin
         m_pend = m_pend | req;
         if (cause_clr) m_cause = 4'b0000;
         cool_left--;
      end else if ((req | m_pend) != 3'b000) begin
         m_cause = {1'b0, req | m_pend};
         m_pend = 3'b000;
         m_count = (m_count < 255) ? m_count + 1 : 255;
         hold_left = HOLD;
      end else if (cause_clr) begin
         m_cause = 4'b0000;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [2:0] r, input logic c);
      req = r;
      cause_clr = c;
      tick();
      req = 3'b000;
      cause_clr = 1'b0;
   endtask

   task automatic count_low(output int e);
      e = 0;
      while (sys_rst_n === 1'b0 && e < 2000) begin
         tick();
         e++;
      end
   endtask

   task automatic wait_idle(output int e, output bit ok);
      e = 0;
      while (busy !== 1'b0 && e < 2000) begin
         tick();
         e++;
      end
      ok = (busy === 1'b0);
   endtask

   task automatic test_reset();
      int e;
      bit ok;
      reset_n = 1'b0;
      repeat (3) tick();
      n_tests++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL por_rst_n got %b exp 0", sys_rst_n); end
      n_tests++; if (cause !== 4'b1000) begin n_fail++; $display("FAIL por_cause got %b exp 1000", cause); end
      n_tests++; if (rst_count !== 8'd0) begin n_fail++; $display("FAIL por_count got %0d exp 0", rst_count); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL por_busy got %b exp 1", busy); end
      reset_n = 1'b1;
      count_low(e);
      n_tests++; if (e != HOLD) begin n_fail++; $display("FAIL por_hold got %0d exp %0d", e, HOLD); end
      n_tests++; if (cause !== 4'b1000 || rst_count !== 8'd0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL por_release got cause=%b count=%0d busy=%b exp 1000/0/1", cause, rst_count, busy);
      end
      wait_idle(e, ok);
      n_tests++; if (!ok || e != COOL) begin n_fail++; $display("FAIL por_cooldown got %0d ok=%0b exp %0d", e, ok, COOL); end
   endtask

   task automatic test_watchdog();
      int e;
      bit ok;
      pulse(3'b001, 1'b0);
      n_tests++; if (sys_rst_n !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL wd_latency got rst_n=%b busy=%b exp 0/1", sys_rst_n, busy);
      end
      n_tests++; if (cause !== 4'b0001 || rst_count !== 8'd1) begin
         n_fail++; $display("FAIL wd_cause got cause=%b count=%0d exp 0001/1", cause, rst_count);
      end
      count_low(e);
      n_tests++; if (e != HOLD) begin n_fail++; $display("FAIL wd_hold got %0d exp %0d", e, HOLD); end
      wait_idle(e, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL wd_idle got busy=%b exp 0", busy); end
   endtask

   task automatic test_extension();
      int e;
      bit ok;
      pulse(3'b001, 1'b0);
      repeat (150) tick();
      n_tests++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL ext_mid got %b exp 0", sys_rst_n); end
      pulse(3'b010, 1'b0);
      count_low(e);
      n_tests++; if (150 + 1 + e != 150 + 1 + HOLD) begin
         n_fail++; $display("FAIL ext_total got %0d exp %0d", 151 + e, 151 + HOLD);
      end
      n_tests++; if (cause !== 4'b0011 || rst_count !== 8'd2) begin
         n_fail++; $display("FAIL ext_cause got cause=%b count=%0d exp 0011/2", cause, rst_count);
      end
      wait_idle(e, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL ext_idle got busy=%b exp 0", busy); end
   endtask

   task automatic test_cooldown();
      int e;
      bit ok;
      pulse(3'b001, 1'b0);
      count_low(e);
      repeat (5) tick();
      pulse(3'b100, 1'b0);
      n_tests++; if (sys_rst_n !== 1'b1 || busy !== 1'b1 || cause !== 4'b0001) begin
         n_fail++; $display("FAIL cd_defer got rst_n=%b busy=%b cause=%b exp 1/1/0001", sys_rst_n, busy, cause);
      end
      wait_idle(e, ok);
      n_tests++; if (!ok || e != COOL - 6) begin n_fail++; $display("FAIL cd_len got %0d ok=%0b exp %0d", e, ok, COOL - 6); end
      tick();
      n_tests++; if (sys_rst_n !== 1'b0 || cause !== 4'b0100 || rst_count !== 8'd4) begin
         n_fail++; $display("FAIL cd_fire got rst_n=%b cause=%b count=%0d exp 0/0100/4", sys_rst_n, cause, rst_count);
      end
      count_low(e);
      wait_idle(e, ok);
   endtask

   task automatic test_simultaneous();
      int e;
      bit ok;
      pulse(3'b010, 1'b1);
      n_tests++; if (cause !== 4'b0010 || rst_count !== 8'd5 || sys_rst_n !== 1'b0) begin
         n_fail++; $display("FAIL sim_clr_req got cause=%b count=%0d rst_n=%b exp 0010/5/0", cause, rst_count, sys_rst_n);
      end
      repeat (3) tick();
      pulse(3'b000, 1'b1);
      n_tests++; if (cause !== 4'b0010) begin n_fail++; $display("FAIL sim_clr_assert got %b exp 0010", cause); end
      count_low(e);
      wait_idle(e, ok);
      pulse(3'b000, 1'b1);
      n_tests++; if (cause !== 4'b0000 || busy !== 1'b0) begin
         n_fail++; $display("FAIL sim_clr_idle got cause=%b busy=%b exp 0000/0", cause, busy);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         req = ($urandom_range(0, 99) < 3) ? 3'($urandom_range(1, 7)) : 3'b000;
         cause_clr = ($urandom_range(0, 19) == 0);
         tick();
         n_tests++;
         if (sys_rst_n !== (hold_left == 0) || busy !== (hold_left > 0 || cool_left > 0) ||
             cause !== m_cause || rst_count !== 8'(m_count)) begin
            n_fail++;
            $display("FAIL rnd_cycle%0d got rst_n=%b busy=%b cause=%b count=%0d exp %b/%b/%b/%0d", i,
                     sys_rst_n, busy, cause, rst_count, hold_left == 0, hold_left > 0 || cool_left > 0, m_cause, m_count);
         end
      end
      req = 3'b000;
      cause_clr = 1'b0;
   endtask

   task automatic test_saturation();
      int e;
      bit ok;
      for (int i = 0; i < 260; i++) begin
         wait_idle(e, ok);
         if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL sat_timeout got busy=%b exp 0", busy);
            break;
         end
         pulse(3'($urandom_range(1, 7)), 1'b0);
      end
      n_tests++; if (rst_count !== 8'd255 || m_count != 255) begin
         n_fail++; $display("FAIL sat_count got %0d exp 255", rst_count);
      end
   endtask

   task automatic test_async();
      int e;
      pulse(3'b001, 1'b0);
      repeat (20) tick();
      #2 reset_n = 1'b0;
      #1;
      n_tests++; if (sys_rst_n !== 1'b0 || cause !== 4'b1000 || rst_count !== 8'd0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL async_vals got rst_n=%b cause=%b count=%0d busy=%b exp 0/1000/0/1", sys_rst_n, cause, rst_count, busy);
      end
      tick();
      reset_n = 1'b1;
      count_low(e);
      n_tests++; if (e != HOLD) begin n_fail++; $display("FAIL async_hold got %0d exp %0d", e, HOLD); end
   endtask

   initial begin
      test_reset();
      test_watchdog();
      test_extension();
      test_cooldown();
      test_simultaneous();
      test_random();
      test_saturation();
      test_async();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
